sam_memory_interface: RTL and testbench
=======================================

// Module: sam_memory_interface
// PURPOSE
//   Main-memory stage that consumes the controller's memory-strobe control bits
//   and returns the wait_ condition that the controller's branch mux samples.
//   Holds a synchronous word memory with a fixed, parameterised access latency.
//   Latches MAR/MBR at request time and returns read data for the MBR load path.
//   Single clock domain; sits between the controller's control bus and the datapath.
// PARAMETERS
//   ADDR_W   12  address width (MAR width)
//   DATA_W   16  word width (AC/MBR width)
//   DEPTH    4096  number of words; must be <= 2**ADDR_W
//   LATENCY  3   cycles wait_ stays high per access; legal range 1..15
// PORTS
//   clk      in   1       rising-edge clock
//   reset    in   1       asynchronous, active-high reset
//   mem_rd   in   1       read strobe from control bus
//   mem_wr   in   1       write strobe from control bus
//   addr     in   ADDR_W  address from MAR, sampled at request accept
//   wdata    in   DATA_W  write data from MBR, sampled at request accept
//   wait_    out  1       1 = access in progress; controller loops while 1
//   rdata    out  DATA_W  last read word, held until the next read completes
//   rd_valid out  1       one-cycle pulse, in the cycle after a read completes
//   err      out  1       one-cycle pulse on an illegal request
// BEHAVIOUR
//   Reset (async): state=IDLE, wait_=0, rdata=0, rd_valid=0, err=0, cnt=0,
//     strobe history=0. Memory contents are not cleared.
//   Request detect: req = (mem_rd|mem_wr) & ~prev, where prev is the registered
//     (mem_rd|mem_wr) from the previous cycle. prev updates in every state.
//     A strobe held high for many cycles is one request.
//   FSM states: IDLE, BUSY.
//   IDLE, req, exactly one strobe high: latch addr, wdata and op (rd/wr).
//     Set wait_<=1 and cnt<=LATENCY-1, then go to BUSY.
//   IDLE, req with both strobes high: no access, err<=1 for one cycle, stay in IDLE.
//   IDLE, addr>=DEPTH on accept: the access proceeds normally. A write is dropped.
//     A read returns 0. err pulses in the completion cycle.
//   BUSY, cnt!=0: cnt<=cnt-1. All new strobes and edges are ignored (no queueing).
//   BUSY, cnt==0 (completion edge): perform the access. A write stores wdata_lat.
//     A read sets rdata<=mem[addr_lat] and rd_valid<=1 for one cycle.
//     Set wait_<=0 and go to IDLE.
//   wait_ is high for exactly LATENCY cycles, starting the cycle after the accept edge.
//   The earliest next accept is the edge after completion, and it requires a fresh
//     rising strobe.
//   Latched addr/wdata are used, so MAR/MBR may change while BUSY.
//   Reset mid-access: the access is abandoned. No memory write occurs and wait_ drops
//     at once.
//   rd_valid and err are never high for more than 1 consecutive cycle.
//   A write never alters rdata.
// TESTING
//   1 Reset with LATENCY=3 -> wait_=0, rdata=0, rd_valid=0, err=0.
//   2 Write then read: pulse mem_wr addr=0x010 wdata=0xBEEF -> wait_ high 3 cycles.
//     Then pulse mem_rd addr=0x010 -> after 3 wait cycles rdata=0xBEEF and
//     rd_valid pulses once.
//   3 Hold mem_rd high for 10 cycles -> exactly one access: wait_ high 3 cycles,
//     one rd_valid, no second access.
//   4 mem_rd and mem_wr rise together -> err pulses once, wait_ stays 0,
//     memory is unchanged.
//   5 Write 0x1234 to 0x020; during BUSY change addr/wdata and toggle mem_rd ->
//     only mem[0x020]=0x1234 is written, no extra access starts.
//   6 Assert reset in the 2nd BUSY cycle of a write of 0x5555 to 0x030 -> wait_=0
//     immediately, and a later read of 0x030 returns the old value.
//   7 LATENCY=1 -> wait_ high exactly 1 cycle per access.
//     Read addr=DEPTH (DEPTH<2**ADDR_W) -> rdata=0 and err pulses.

Source files
------------

// File: rtl/sam_memory_interface.sv
// sam_memory_interface
// Main-memory stage behind the controller's memory strobes. A rising strobe
// (read or write) starts one fixed-latency access. wait_ holds the controller
// in its wait loop while the access is in progress. The address and write data
// are captured when the request is accepted, so MAR/MBR may change meanwhile.
module sam_memory_interface #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              wait_,
    output logic [DATA_W-1:0] rdata,
    output logic              rd_valid,
    output logic              err
);

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      CNT_INIT  = 4'(LATENCY - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t              state_reg, state_next;
    logic [3:0]          cnt_reg, cnt_next;
    logic                prev_reg;
    logic [ADDR_W-1:0]   addr_lat_reg, addr_lat_next;
    logic [DATA_W-1:0]   wdata_lat_reg, wdata_lat_next;
    logic                op_rd_reg, op_rd_next;
    logic                oor_reg, oor_next;
    logic                wait_reg, wait_next;
    logic [DATA_W-1:0]   rdata_reg;
    logic                rd_valid_reg, rd_valid_next;
    logic                err_reg, err_next;

    logic                strobe;
    logic                req;
    logic                rd_load;
    logic                mem_we;
    logic [IDX_W-1:0]    idx;

    logic [DATA_W-1:0]   mem [DEPTH];

    assign strobe = mem_rd | mem_wr;
    // Only a rising edge of the combined strobe counts as a new request.
    assign req    = strobe & ~prev_reg;
    assign idx    = addr_lat_reg[IDX_W-1:0];

    // State, counter, latched request and one-cycle status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            prev_reg      <= 1'b0;
            addr_lat_reg  <= '0;
            wdata_lat_reg <= '0;
            op_rd_reg     <= 1'b0;
            oor_reg       <= 1'b0;
            wait_reg      <= 1'b0;
            rd_valid_reg  <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            prev_reg      <= strobe;
            addr_lat_reg  <= addr_lat_next;
            wdata_lat_reg <= wdata_lat_next;
            op_rd_reg     <= op_rd_next;
            oor_reg       <= oor_next;
            wait_reg      <= wait_next;
            rd_valid_reg  <= rd_valid_next;
            err_reg       <= err_next;
        end
    end

    // Next-state logic: accept in IDLE, count down in BUSY, complete at cnt==0.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        addr_lat_next  = addr_lat_reg;
        wdata_lat_next = wdata_lat_reg;
        op_rd_next     = op_rd_reg;
        oor_next       = oor_reg;
        wait_next      = wait_reg;
        rd_valid_next  = 1'b0;
        err_next       = 1'b0;
        rd_load        = 1'b0;
        mem_we         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (req) begin
                    if (mem_rd && mem_wr) begin
                        // Conflicting strobes: refuse the request outright.
                        err_next = 1'b1;
                    end else begin
                        addr_lat_next  = addr;
                        wdata_lat_next = wdata;
                        op_rd_next     = mem_rd;
                        oor_next       = ({1'b0, addr} >= DEPTH_LIM);
                        wait_next      = 1'b1;
                        cnt_next       = CNT_INIT;
                        state_next     = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    // Completion edge: out-of-range accesses still take the
                    // full latency but touch no storage and flag err.
                    wait_next  = 1'b0;
                    state_next = IDLE;
                    err_next   = oor_reg;
                    if (op_rd_reg) begin
                        rd_load       = 1'b1;
                        rd_valid_next = 1'b1;
                    end else if (!oor_reg) begin
                        mem_we = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Word storage; no reset so it maps onto block RAM and survives reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= wdata_lat_reg;
        end
    end

    // Registered read data, held until the next read completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_reg <= '0;
        end else if (rd_load) begin
            rdata_reg <= oor_reg ? '0 : mem[idx];
        end
    end

    assign wait_    = wait_reg;
    assign rdata    = rdata_reg;
    assign rd_valid = rd_valid_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_sam_memory_interface.sv
// Testbench for sam_memory_interface: two instances (LATENCY 3 and 1, both
// with DEPTH below 2**ADDR_W), directed scenarios then random transactions
// checked against an array-based reference of memory contents.
module tb_sam_memory_interface;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 3072;
    localparam int LAT_A  = 3;
    localparam int LAT_B  = 1;

    logic clk = 1'b0;
    logic reset;
    logic rd, wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int sel;

    logic rd_a, wr_a, rd_b, wr_b;
    logic wait_a, rd_valid_a, err_a, wait_b, rd_valid_b, err_b;
    logic [DATA_W-1:0] rdata_a, rdata_b;

    assign rd_a = (sel == 0) && rd;
    assign wr_a = (sel == 0) && wr;
    assign rd_b = (sel == 1) && rd;
    assign wr_b = (sel == 1) && wr;

    sam_memory_interface #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .LATENCY(LAT_A)) dut_a (
        .clk(clk), .reset(reset), .mem_rd(rd_a), .mem_wr(wr_a), .addr(addr), .wdata(wdata),
        .wait_(wait_a), .rdata(rdata_a), .rd_valid(rd_valid_a), .err(err_a)
    );

    sam_memory_interface #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .LATENCY(LAT_B)) dut_b (
        .clk(clk), .reset(reset), .mem_rd(rd_b), .mem_wr(wr_b), .addr(addr), .wdata(wdata),
        .wait_(wait_b), .rdata(rdata_b), .rd_valid(rd_valid_b), .err(err_b)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference: memory contents and last completed read per instance.
    logic [DATA_W-1:0] ref_mem [2][4096];
    bit                written [2][4096];
    logic [DATA_W-1:0] exp_rdata [2];

    // Observation counters, sampled on the falling edge.
    int cyc = 0;
    int n_wait [2];
    int n_rv [2];
    int n_err [2];
    int run [2];
    int max_run [2];
    int rise_cyc [2];
    bit prev_wait [2];
    logic [DATA_W-1:0] rv_data [2];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic mon(input int i, input logic wt, input logic rv, input logic er, input logic [DATA_W-1:0] rdv);
        if (wt === 1'b1) begin
            n_wait[i]++;
            run[i]++;
            if (run[i] > max_run[i]) max_run[i] = run[i];
            if (!prev_wait[i]) rise_cyc[i] = cyc;
        end else begin
            run[i] = 0;
        end
        prev_wait[i] = (wt === 1'b1);
        if (rv === 1'b1) begin
            n_rv[i]++;
            rv_data[i] = rdv;
        end
        if (er === 1'b1) n_err[i]++;
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        mon(0, wait_a, rd_valid_a, err_a, rdata_a);
        mon(1, wait_b, rd_valid_b, err_b, rdata_b);
    end

    function automatic logic [DATA_W-1:0] cur_rdata(input int i);
        return (i == 0) ? rdata_a : rdata_b;
    endfunction

    // One strobe pulse of 'hold' cycles on the selected instance, then a
    // settling window; all expectations come from the reference arrays.
    task automatic access(input bit r, input bit w, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input int hold, input string tag);
        int i, lat, w0, v0, e0, acc, win;
        bit oor;
        logic [DATA_W-1:0] exp_val;
        i   = sel;
        lat = (i == 0) ? LAT_A : LAT_B;
        oor = (int'(a) >= DEPTH);
        w0  = n_wait[i];
        v0  = n_rv[i];
        e0  = n_err[i];
        max_run[i] = 0;
        win = hold + lat + 3;
        acc = -1;
        rd = r; wr = w; addr = a; wdata = d;
        for (int c = 0; c < win; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) acc = cyc;
            if (c == hold - 1) begin
                rd = 1'b0;
                wr = 1'b0;
            end
        end
        exp_val = oor ? '0 : ref_mem[i][a];
        if (r && w) begin
            check({tag, " wait"}, 32'(n_wait[i] - w0), 32'(0));
            check({tag, " rv"},   32'(n_rv[i] - v0),   32'(0));
            check({tag, " err"},  32'(n_err[i] - e0),  32'(1));
        end else begin
            check({tag, " wait"},  32'(n_wait[i] - w0), 32'(lat));
            check({tag, " run"},   32'(max_run[i]),     32'(lat));
            check({tag, " rise"},  32'(rise_cyc[i]),    32'(acc));
            check({tag, " rv"},    32'(n_rv[i] - v0),   32'(r));
            check({tag, " err"},   32'(n_err[i] - e0),  32'(oor));
            if (r) begin
                check({tag, " rdata"}, 32'(rv_data[i]), 32'(exp_val));
                exp_rdata[i] = exp_val;
            end else if (!oor) begin
                ref_mem[i][a] = d;
                written[i][a] = 1'b1;
            end
            check({tag, " hold"}, 32'(cur_rdata(i)), 32'(exp_rdata[i]));
        end
        $display("txn %s sel=%0d rd=%0d wr=%0d addr=%03h wdata=%04h rdata=%04h", tag, i, r, w, a, d, cur_rdata(i));
    endtask

    initial begin
        int w0, v0, e0;
        for (int i = 0; i < 2; i++) begin
            exp_rdata[i] = '0;
            n_wait[i] = 0; n_rv[i] = 0; n_err[i] = 0;
            run[i] = 0; max_run[i] = 0; rise_cyc[i] = -1; prev_wait[i] = 0;
            rv_data[i] = '0;
        end
        sel = 0; rd = 0; wr = 0; addr = '0; wdata = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // 1: reset state
        check("rst wait_a", 32'(wait_a), 32'(0));
        check("rst rdata_a", 32'(rdata_a), 32'(0));
        check("rst rv_a", 32'(rd_valid_a), 32'(0));
        check("rst err_a", 32'(err_a), 32'(0));
        check("rst wait_b", 32'(wait_b), 32'(0));
        check("rst rdata_b", 32'(rdata_b), 32'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 2: write then read
        access(1'b0, 1'b1, 12'h010, 16'hBEEF, 1, "wr010");
        access(1'b1, 1'b0, 12'h010, 16'h0000, 1, "rd010");

        // 3: long held read is a single access
        access(1'b1, 1'b0, 12'h010, 16'h0000, 10, "hold10");

        // 4: both strobes together
        access(1'b1, 1'b1, 12'h010, 16'h0000, 2, "both");
        access(1'b1, 1'b0, 12'h010, 16'h0000, 1, "rd_after_both");

        // 5: inputs disturbed while busy
        access(1'b0, 1'b1, 12'h021, 16'h7777, 1, "wr021");
        w0 = n_wait[0]; v0 = n_rv[0]; e0 = n_err[0];
        max_run[0] = 0;
        rd = 0; wr = 1; addr = 12'h020; wdata = 16'h1234;
        @(posedge clk); #1;
        wr = 0; addr = 12'h021; wdata = 16'hDEAD;
        @(posedge clk); #1;
        rd = 1;
        repeat (5) @(posedge clk);
        #1;
        rd = 0;
        repeat (3) @(posedge clk);
        #1;
        check("busy_ign wait", 32'(n_wait[0] - w0), 32'(LAT_A));
        check("busy_ign rv", 32'(n_rv[0] - v0), 32'(0));
        check("busy_ign err", 32'(n_err[0] - e0), 32'(0));
        ref_mem[0][12'h020] = 16'h1234;
        written[0][12'h020] = 1'b1;
        $display("txn busy_ign sel=0 wr addr=020 wdata=1234 with disturbed inputs");
        access(1'b1, 1'b0, 12'h020, 16'h0000, 1, "rd020");
        access(1'b1, 1'b0, 12'h021, 16'h0000, 1, "rd021");

        // 6: reset in the second busy cycle of a write
        access(1'b0, 1'b1, 12'h030, 16'h0A0A, 1, "wr030");
        rd = 0; wr = 1; addr = 12'h030; wdata = 16'h5555;
        @(posedge clk); #1;
        wr = 0;
        @(posedge clk); #1;
        check("pre_rst wait", 32'(wait_a), 32'(1));
        reset = 1'b1;
        #1;
        check("mid_rst wait", 32'(wait_a), 32'(0));
        check("mid_rst rdata", 32'(rdata_a), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        $display("txn mid_rst sel=0 write 5555 to 030 abandoned");
        access(1'b1, 1'b0, 12'h030, 16'h0000, 1, "rd030");

        // 7: latency 1 instance and out-of-range addresses
        sel = 1;
        access(1'b0, 1'b1, 12'h100, 16'hCAFE, 1, "b_wr100");
        access(1'b1, 1'b0, 12'h100, 16'h0000, 1, "b_rd100");
        access(1'b1, 1'b0, 12'(DEPTH), 16'h0000, 1, "b_rd_oor");
        access(1'b0, 1'b1, 12'(DEPTH - 1), 16'h0F0F, 1, "b_wr_last");
        access(1'b1, 1'b0, 12'(DEPTH - 1), 16'h0000, 1, "b_rd_last");
        sel = 0;
        access(1'b0, 1'b1, 12'(DEPTH), 16'h9999, 1, "a_wr_oor");
        access(1'b1, 1'b0, 12'(DEPTH), 16'h0000, 1, "a_rd_oor");

        // Random traffic against the reference arrays
        for (int t = 0; t < 40; t++) begin
            int p, k, h;
            logic [ADDR_W-1:0] a;
            logic [DATA_W-1:0] d;
            bit r, w;
            sel = int'($urandom_range(0, 1));
            k = int'($urandom_range(0, 11));
            if (k == 0)      a = 12'(DEPTH);
            else if (k == 1) a = 12'hFFF;
            else if (k == 2) a = 12'(DEPTH - 1);
            else             a = 12'(k * 64);
            d = 16'($urandom);
            h = int'($urandom_range(1, 6));
            p = int'($urandom_range(0, 9));
            r = (p == 0) || (p >= 5);
            w = (p < 5);
            if (r && !w && int'(a) < DEPTH && !written[sel][a]) begin
                r = 1'b0;
                w = 1'b1;
            end
            access(r, w, a, d, h, $sformatf("rnd%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
